cam_rx_page_ctrl: RTL and testbench

- Page-pool controller for the camera RX packet RAM.
- Allocates free pages to the packetizer (write side) and queues filled pages in arrival order for the CSR/SPI reader (read side).
- Stores 16-bit per-page flags; generates rx_pending and rx_ram_lost for the CSR block.
- Sits between the packetizer, the dual-port RX RAM address high bits and cam_csr.

---
 rtl/cam_rx_pkg.sv | 22 ++
 rtl/cam_rx_flag_mem.sv | 35 +++
 rtl/cam_rx_page_ctrl.sv | 131 +++++++++++++
 tb/tb_cam_rx_page_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_rx_pkg.sv
// Shared definitions for the camera RX page-pool controller:
// write-FSM encoding, default pool size and page-flag field layout.
package cam_rx_pkg;

  // Default number of RX pages (power of two, 2..16).
  localparam int PAGE_NUM_DEFAULT = 8;

  // Per-page flag word layout; the upper byte carries the packet
  // sequence number when the sequence option is built in.
  localparam int FLAG_W       = 16;
  localparam int SEQ_W        = 8;
  localparam int FLAG_SEQ_MSB = 15;
  localparam int FLAG_SEQ_LSB = 8;

  // Write-side FSM: idle, filling a granted page, or swallowing a refused packet.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } w_state_e;

endpackage

// File: rtl/cam_rx_flag_mem.sv
// Per-page flag register file: one synchronous write port, one
// combinational read port, asynchronously cleared by reset_n.
module cam_rx_flag_mem
  import cam_rx_pkg::*;
#(
  parameter  int DEPTH = PAGE_NUM_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FLAG_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FLAG_W-1:0] rdata
);

  logic [FLAG_W-1:0] mem [DEPTH];

  // Flag storage: cleared on reset, written on commit.
  // NOTE: this array is small and the reader sees flags combinationally, so
  // it is built from flops and reset explicitly; a large RAM would not be.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cam_rx_page_ctrl.sv
// Page-pool controller for the camera RX packet RAM. Grants free pages
// to the packetizer, queues filled pages in arrival order for the reader,
// stores per-page flags and reports pending data / lost packets.
// Optional build macro CAM_RX_SEQ_EN: stamps an 8-bit packet sequence
// number into flags[15:8] so the host can detect dropped packets.
module cam_rx_page_ctrl
  import cam_rx_pkg::*;
#(
  parameter  int PAGE_NUM = PAGE_NUM_DEFAULT,
  localparam int PAGE_AW  = $clog2(PAGE_NUM)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_req,
  output logic               wr_grant,
  output logic [PAGE_AW-1:0] wr_page,
  input  logic               wr_commit,
  input  logic [FLAG_W-1:0]  wr_flags,
  output logic               rx_ram_lost,
  output logic               rx_pending,
  output logic [PAGE_AW-1:0] rd_page,
  output logic [FLAG_W-1:0]  rx_ram_rd_flags,
  input  logic               rx_ram_rd_done,
  input  logic               rx_clean_all,
  output logic [PAGE_AW:0]   free_cnt
);

  localparam logic [PAGE_AW:0] PAGES = (PAGE_AW+1)'(PAGE_NUM);
  localparam logic [PAGE_AW:0] PTR_ONE = (PAGE_AW+1)'(1);

  w_state_e state, state_next;
  logic              grant_next, lost_next;
  logic [PAGE_AW:0]  wr_ptr, rd_ptr, filled;
  logic              fill_active, commit_fire, rd_fire;
  logic [FLAG_W-1:0] store_flags;

  // Pointers carry an extra wrap bit so full (filled==PAGE_NUM) and empty differ.
  assign filled      = wr_ptr - rd_ptr;
  assign fill_active = (state == W_FILL);
  assign commit_fire = fill_active && wr_commit;
  assign rd_fire     = rx_ram_rd_done && (filled != '0);

  assign wr_page    = wr_ptr[PAGE_AW-1:0];
  assign rd_page    = rd_ptr[PAGE_AW-1:0];
  assign rx_pending = (filled != '0);
  assign free_cnt   = PAGES - filled - {{PAGE_AW{1'b0}}, fill_active};

  // Write-FSM state and registered grant/lost pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= W_IDLE;
      wr_grant    <= 1'b0;
      rx_ram_lost <= 1'b0;
    end else begin
      state       <= state_next;
      wr_grant    <= grant_next;
      rx_ram_lost <= lost_next;
    end
  end

  // Write-FSM next state: grant if a page is free, otherwise drop the packet.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    grant_next = 1'b0;
    lost_next  = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (wr_req) begin
          if (free_cnt != '0) begin
            grant_next = 1'b1;
            state_next = W_FILL;
          end else begin
            lost_next  = 1'b1;
            state_next = W_DROP;
          end
        end
      end
      W_FILL:  if (wr_commit) state_next = W_IDLE;
      W_DROP:  if (wr_commit) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  // Queue pointers; clean_all snaps rd_ptr to the pre-commit wr_ptr and
  // overrides a same-cycle rd_done, while a same-cycle commit still enqueues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (commit_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rx_clean_all)  rd_ptr <= wr_ptr;
      else if (rd_fire)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef CAM_RX_SEQ_EN
  logic [SEQ_W-1:0] seq_cnt, pkt_seq;

  // Sequence stamp: every request seen in W_IDLE consumes a number, so a
  // refused packet leaves a visible gap in the stored sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt <= '0;
      pkt_seq <= '0;
    end else if ((state == W_IDLE) && wr_req) begin
      pkt_seq <= seq_cnt;
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  assign store_flags = {pkt_seq, wr_flags[FLAG_SEQ_LSB-1:0]};
`else
  assign store_flags = wr_flags;
`endif

  cam_rx_flag_mem #(
    .DEPTH (PAGE_NUM)
  ) u_flag_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit_fire),
    .waddr   (wr_page),
    .wdata   (store_flags),
    .raddr   (rd_page),
    .rdata   (rx_ram_rd_flags)
  );

endmodule

// File: tb/tb_cam_rx_page_ctrl.sv
// Directed bench for cam_rx_page_ctrl (PAGE_NUM=8). Inputs change 1 time
// unit after a rising edge; outputs are checked at the same offset.
module tb_cam_rx_page_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_req;
  logic        wr_grant;
  logic [2:0]  wr_page;
  logic        wr_commit;
  logic [15:0] wr_flags;
  logic        rx_ram_lost;
  logic        rx_pending;
  logic [2:0]  rd_page;
  logic [15:0] rx_ram_rd_flags;
  logic        rx_ram_rd_done;
  logic        rx_clean_all;
  logic [3:0]  free_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cam_rx_page_ctrl #(.PAGE_NUM(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_req          (wr_req),
    .wr_grant        (wr_grant),
    .wr_page         (wr_page),
    .wr_commit       (wr_commit),
    .wr_flags        (wr_flags),
    .rx_ram_lost     (rx_ram_lost),
    .rx_pending      (rx_pending),
    .rd_page         (rd_page),
    .rx_ram_rd_flags (rx_ram_rd_flags),
    .rx_ram_rd_done  (rx_ram_rd_done),
    .rx_clean_all    (rx_clean_all),
    .free_cnt        (free_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected stored flag word for a packet with sequence number s.
  function automatic logic [15:0] expf(input logic [7:0] s, input logic [15:0] f);
`ifdef CAM_RX_SEQ_EN
    return {s, f[7:0]};
`else
    return f;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_pulse();
    wr_req = 1'b1; tick(); wr_req = 1'b0;
  endtask

  task automatic commit_pulse(input logic [15:0] f);
    wr_commit = 1'b1; wr_flags = f; tick(); wr_commit = 1'b0; wr_flags = '0;
  endtask

  task automatic done_pulse();
    rx_ram_rd_done = 1'b1; tick(); rx_ram_rd_done = 1'b0;
  endtask

  task automatic alloc_commit(input logic [15:0] f);
    req_pulse();
    commit_pulse(f);
  endtask

  initial begin
    reset_n = 1'b0; wr_req = 1'b0; wr_commit = 1'b0; wr_flags = '0;
    rx_ram_rd_done = 1'b0; rx_clean_all = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_grant",   32'(wr_grant), 0);
    check("rst_lost",    32'(rx_ram_lost), 0);
    check("rst_wr_page", 32'(wr_page), 0);
    check("rst_rd_page", 32'(rd_page), 0);
    check("rst_pending", 32'(rx_pending), 0);
    check("rst_flags",   32'(rx_ram_rd_flags), 0);
    check("rst_free",    32'(free_cnt), 8);

    // First grant and commit (seq 0, page 0)
    req_pulse();
    check("grant1",       32'(wr_grant), 1);
    check("grant1_page",  32'(wr_page), 0);
    check("grant1_free",  32'(free_cnt), 7);
    check("grant1_pend",  32'(rx_pending), 0);
    tick();
    check("grant1_pulse", 32'(wr_grant), 0);
    commit_pulse(16'h00FA);
    check("c1_pending", 32'(rx_pending), 1);
    check("c1_rd_page", 32'(rd_page), 0);
    check("c1_flags",   32'(rx_ram_rd_flags), 32'(expf(8'd0, 16'h00FA)));
    check("c1_free",    32'(free_cnt), 7);

    // Fill the remaining 7 pages (seq 1..7)
    for (int i = 1; i < 8; i++) alloc_commit(16'h5A00 + 16'(i));
    check("full_free", 32'(free_cnt), 0);
    check("full_pend", 32'(rx_pending), 1);

    // 9th request refused (seq 8); its commit is discarded
    req_pulse();
    check("refuse_lost",  32'(rx_ram_lost), 1);
    check("refuse_grant", 32'(wr_grant), 0);
    tick();
    check("refuse_pulse", 32'(rx_ram_lost), 0);
    commit_pulse(16'hDEAD);
    check("drop_free",    32'(free_cnt), 0);
    check("drop_rd_page", 32'(rd_page), 0);
    check("drop_flags0",  32'(rx_ram_rd_flags), 32'(expf(8'd0, 16'h00FA)));

    // Drain all 8 pages in order
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_page%0d", i), 32'(rd_page), 32'(i));
      if (i > 0)
        check($sformatf("drain_flags%0d", i), 32'(rx_ram_rd_flags),
              32'(expf(8'(i), 16'h5A00 + 16'(i))));
      done_pulse();
    end
    check("drained_pend", 32'(rx_pending), 0);
    check("drained_free", 32'(free_cnt), 8);

    // Three queued (seq 9..11, pages 0..2), read them one by one
    for (int i = 0; i < 3; i++) alloc_commit(16'h0C00 + 16'(i));
    check("q3_free", 32'(free_cnt), 5);
    check("q3_page", 32'(rd_page), 0);
    check("q3_flags0", 32'(rx_ram_rd_flags), 32'(expf(8'd9, 16'h0C00)));
    done_pulse();
    check("q3_rd1", 32'(rd_page), 1);
    check("q3_pend1", 32'(rx_pending), 1);
    done_pulse();
    check("q3_rd2", 32'(rd_page), 2);
    check("q3_flags2", 32'(rx_ram_rd_flags), 32'(expf(8'd11, 16'h0C02)));
    done_pulse();
    check("q3_rd3", 32'(rd_page), 3);
    check("q3_pend3", 32'(rx_pending), 0);
    done_pulse();
    check("extra_rd_page", 32'(rd_page), 3);
    check("extra_free",    32'(free_cnt), 8);
    check("extra_pend",    32'(rx_pending), 0);

    // Empty queue: commit and rd_done together (seq 12, page 3)
    req_pulse();
    wr_commit = 1'b1; wr_flags = 16'h0033; rx_ram_rd_done = 1'b1;
    tick();
    wr_commit = 1'b0; wr_flags = '0; rx_ram_rd_done = 1'b0;
    check("simul_pend",  32'(rx_pending), 1);
    check("simul_page",  32'(rd_page), 3);
    check("simul_flags", 32'(rx_ram_rd_flags), 32'(expf(8'd12, 16'h0033)));
    check("simul_free",  32'(free_cnt), 7);
    done_pulse();
    check("simul_drain", 32'(rx_pending), 0);

    // Five queued (seq 13..17, pages 4..7,0) plus one filling (seq 18, page 1)
    for (int i = 0; i < 5; i++) alloc_commit(16'h0500 + 16'(i));
    req_pulse();
    check("pre_clean_free", 32'(free_cnt), 2);
    rx_clean_all = 1'b1; rx_ram_rd_done = 1'b1;
    tick();
    rx_clean_all = 1'b0; rx_ram_rd_done = 1'b0;
    check("clean_pend", 32'(rx_pending), 0);
    check("clean_free", 32'(free_cnt), 7);
    check("clean_page", 32'(rd_page), 1);
    commit_pulse(16'h0077);
    check("post_clean_pend",  32'(rx_pending), 1);
    check("post_clean_page",  32'(rd_page), 1);
    check("post_clean_flags", 32'(rx_ram_rd_flags), 32'(expf(8'd18, 16'h0077)));
    check("post_clean_free",  32'(free_cnt), 7);

    // Commit and clean_all in the same cycle (seq 19, page 2)
    req_pulse();
    wr_commit = 1'b1; wr_flags = 16'h0099; rx_clean_all = 1'b1;
    tick();
    wr_commit = 1'b0; wr_flags = '0; rx_clean_all = 1'b0;
    check("cc_pend",  32'(rx_pending), 1);
    check("cc_page",  32'(rd_page), 2);
    check("cc_flags", 32'(rx_ram_rd_flags), 32'(expf(8'd19, 16'h0099)));
    check("cc_free",  32'(free_cnt), 7);

    // Commit while idle is ignored
    commit_pulse(16'h1234);
    check("idle_commit_free", 32'(free_cnt), 7);
    check("idle_commit_wpg",  32'(wr_page), 3);

    // Reset in the middle of a packet
    req_pulse();
    check("mid_free", 32'(free_cnt), 6);
    reset_n = 1'b0;
    #1;
    check("midrst_free",  32'(free_cnt), 8);
    check("midrst_pend",  32'(rx_pending), 0);
    check("midrst_grant", 32'(wr_grant), 0);
    tick();
    reset_n = 1'b1;
    tick();
    commit_pulse(16'h4321);
    check("midrst_commit_pend", 32'(rx_pending), 0);
    check("midrst_commit_free", 32'(free_cnt), 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
